// File: rtl/pcpi_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pcpi_loader_pkg                                           |
// | Brief    : Shared types and sizes for the PCPI nibble loader.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pcpi_loader_pkg;

  localparam int NIBBLES = 8;
  localparam int CNT_W   = 3;
  localparam int TMO_W   = 10;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  function automatic logic [3:0] nib_of(input logic [31:0] word, input logic [CNT_W-1:0] idx);
    return word[4*idx +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : strobe_edge_det                                           |
// | Brief    : Single-cycle pulse on each rising edge of a level input.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module strobe_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);

  logic r_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_q <= 1'b0;
    end else begin
      r_prev_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~r_prev_q;

endmodule
`default_nettype wire

// File: rtl/pcpi_nibble_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pcpi_nibble_loader                                        |
// | Brief    : Assembles a PCPI instruction from pin nibbles, issues it  |
// |            and streams the 32-bit result back out nibble by nibble.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pcpi_nibble_loader
  import pcpi_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  nib_in,
  input  logic        nib_strobe,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic        pcpi_wait,
  input  logic [31:0] pcpi_rd,
  output logic [3:0]  res_nib,
  output logic        rd_mode,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NIBBLES - 1);
  // Abort fires on the WAIT cycle that would bring the counter to TIMEOUT_CYCLES.
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               valid_q, valid_d;
  logic [31:0]        insn_q, insn_d;
  logic [31:0]        result_q, result_d;
  logic               err_q, err_d;
  logic               w_event;

  strobe_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (nib_strobe),
    .pulse_o (w_event)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      tmo_q    <= '0;
      valid_q  <= 1'b0;
      insn_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      valid_q  <= valid_d;
      insn_q   <= insn_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    valid_d  = valid_q;
    insn_d   = insn_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      ST_LOAD: begin
        if (w_event) begin
          insn_d[4*cnt_q +: 4] = nib_in;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) begin
            err_d = 1'b0;
          end
          if (cnt_q == c_cnt_last) begin
            state_d = ST_ISSUE;
            valid_d = 1'b1;
            tmo_d   = '0;
          end
        end
      end

      ST_ISSUE, ST_WAIT: begin
        // Ready takes priority over both the wait hold-off and the abort.
        if (pcpi_ready) begin
          result_d = pcpi_wr ? pcpi_rd : 32'h0;
          valid_d  = 1'b0;
          state_d  = ST_READ;
          cnt_d    = '0;
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end else if (pcpi_wait) begin
          tmo_d = '0;
        end else if (tmo_q == c_tmo_last) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_LOAD;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_READ: begin
        if (w_event) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == c_cnt_last) begin
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign pcpi_valid = valid_q;
  assign pcpi_insn  = insn_q;
  assign rd_mode    = (state_q == ST_READ);
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign err        = err_q;
  assign res_nib    = rd_mode ? nib_of(result_q, cnt_q) : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_nibble_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pcpi_nibble_loader                                     |
// | Brief    : Directed self-checking bench for pcpi_nibble_loader.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pcpi_nibble_loader;

  logic        clk;
  logic        rst;
  logic [3:0]  nib_in;
  logic        nib_strobe;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic        pcpi_wait;
  logic [31:0] pcpi_rd;
  logic [3:0]  res_nib;
  logic        rd_mode;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;

  pcpi_nibble_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .nib_in     (nib_in),
    .nib_strobe (nib_strobe),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_wait  (pcpi_wait),
    .pcpi_rd    (pcpi_rd),
    .res_nib    (res_nib),
    .rd_mode    (rd_mode),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; nib_strobe = 1'b0; pcpi_ready = 1'b0; pcpi_wait = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    nib_in = n; nib_strobe = 1'b1;
    @(negedge clk);
    nib_strobe = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_nib(w[4*i +: 4]);
  endtask

  task automatic pulse_ready(input logic wr, input logic [31:0] rd);
    @(negedge clk);
    pcpi_ready = 1'b1; pcpi_wr = wr; pcpi_rd = rd;
    @(negedge clk);
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pcpi_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pcpi_valid); else passed++;
    total++; if (pcpi_insn !== 32'h0) $display("FAIL reset_insn: got %h want 00000000", pcpi_insn); else passed++;
    total++; if ({res_nib, rd_mode, busy, err} !== 7'b0) $display("FAIL reset_outs: got %b want 0000000", {res_nib, rd_mode, busy, err}); else passed++;
  endtask

  task automatic test_load_issue();
    logic [3:0] nibs [8] = '{4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    for (int i = 0; i < 7; i++) send_nib(nibs[i]);
    total++; if (pcpi_valid !== 1'b0) $display("FAIL load_early_valid: got %b want 0", pcpi_valid); else passed++;
    send_nib(nibs[7]);
    total++; if (pcpi_valid !== 1'b1) $display("FAIL load_valid: got %b want 1", pcpi_valid); else passed++;
    total++; if (pcpi_insn !== 32'h0200000B) $display("FAIL load_insn: got %h want 0200000b", pcpi_insn); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL issue_busy: got %b want 1", busy); else passed++;
    send_nib(4'hF);
    total++; if (pcpi_insn !== 32'h0200000B || pcpi_valid !== 1'b1) $display("FAIL wait_ignore_strobe: got %h/%b want 0200000b/1", pcpi_insn, pcpi_valid); else passed++;
  endtask

  task automatic test_read_wr();
    logic [3:0] exp [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    pulse_ready(1'b1, 32'h12345678);
    total++; if (rd_mode !== 1'b1 || pcpi_valid !== 1'b0 || busy !== 1'b0) $display("FAIL read_enter: got rd=%b v=%b b=%b want 1/0/0", rd_mode, pcpi_valid, busy); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (res_nib !== exp[i]) $display("FAIL read_nib%0d: got %h want %h", i, res_nib, exp[i]); else passed++;
      send_nib(4'h0);
    end
    total++; if (rd_mode !== 1'b0 || res_nib !== 4'h0) $display("FAIL read_exit: got rd=%b nib=%h want 0/0", rd_mode, res_nib); else passed++;
  endtask

  task automatic test_read_nowr();
    send_word(32'h00000013);
    pulse_ready(1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      total++; if (res_nib !== 4'h0 || rd_mode !== 1'b1) $display("FAIL nowr_nib%0d: got %h/%b want 0/1", i, res_nib, rd_mode); else passed++;
      send_nib(4'h0);
    end
  endtask

  task automatic test_timeout();
    send_word(32'hDEADBEEF);
    repeat (16) @(negedge clk);
    total++; if (pcpi_valid !== 1'b1 || err !== 1'b0) $display("FAIL tmo_early: got v=%b e=%b want 1/0", pcpi_valid, err); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b1 || pcpi_valid !== 1'b0 || busy !== 1'b0 || rd_mode !== 1'b0) $display("FAIL tmo_abort: got e=%b v=%b b=%b r=%b want 1/0/0/0", err, pcpi_valid, busy, rd_mode); else passed++;
    send_nib(4'h1);
    total++; if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else passed++;
    for (int i = 1; i < 8; i++) send_nib(4'h0);
    repeat (5) @(negedge clk);
    pcpi_wait = 1'b1;
    repeat (3) @(negedge clk);
    pcpi_wait = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (pcpi_valid !== 1'b1) $display("FAIL wait_extends: got %b want 1", pcpi_valid); else passed++;
    repeat (6) @(negedge clk);
    total++; if (pcpi_valid !== 1'b1 || err !== 1'b0) $display("FAIL wait_early: got v=%b e=%b want 1/0", pcpi_valid, err); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b1 || pcpi_valid !== 1'b0) $display("FAIL wait_abort: got e=%b v=%b want 1/0", err, pcpi_valid); else passed++;
  endtask

  task automatic test_held_strobe();
    do_reset();
    @(negedge clk);
    nib_in = 4'h5; nib_strobe = 1'b1;
    repeat (20) @(negedge clk);
    nib_strobe = 1'b0;
    total++; if (pcpi_insn !== 32'h00000005) $display("FAIL held_insn: got %h want 00000005", pcpi_insn); else passed++;
    for (int i = 1; i < 7; i++) send_nib(4'(i));
    total++; if (pcpi_valid !== 1'b0) $display("FAIL held_count: got %b want 0", pcpi_valid); else passed++;
    send_nib(4'h7);
    total++; if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'h76543215) $display("FAIL held_issue: got %b/%h want 1/76543215", pcpi_valid, pcpi_insn); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_nib(4'hA); send_nib(4'hB); send_nib(4'hC); send_nib(4'hD); send_nib(4'hE);
    total++; if (pcpi_insn !== 32'h000EDCBA) $display("FAIL partial_insn: got %h want 000edcba", pcpi_insn); else passed++;
    do_reset();
    total++; if (pcpi_insn !== 32'h0 || pcpi_valid !== 1'b0) $display("FAIL mid_reset: got %h/%b want 00000000/0", pcpi_insn, pcpi_valid); else passed++;
    for (int i = 0; i < 5; i++) send_nib(4'(i + 1));
    total++; if (pcpi_valid !== 1'b0) $display("FAIL cnt_retained: got %b want 0", pcpi_valid); else passed++;
    do_reset();
    send_word(32'hCAFE1234);
    total++; if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'hCAFE1234) $display("FAIL fresh_load: got %b/%h want 1/cafe1234", pcpi_valid, pcpi_insn); else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (pcpi_valid !== 1'b0 || busy !== 1'b0 || pcpi_insn !== 32'h0) $display("FAIL wait_reset: got v=%b b=%b i=%h want 0/0/00000000", pcpi_valid, busy, pcpi_insn); else passed++;
  endtask

  initial begin
    rst = 1'b1; nib_in = 4'h0; nib_strobe = 1'b0;
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_wait = 1'b0; pcpi_rd = 32'h0;
    test_reset();
    test_load_issue();
    test_read_wr();
    test_read_nowr();
    test_timeout();
    test_held_strobe();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
